// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM duty meter and its divider.
package pwm_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_OUT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 65535;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MEAS = 1'b1
    } meas_state_t;

endpackage

// File: rtl/pwm_seq_div.sv
// Restoring divider producing floor((high << OUT_W) / period), one quotient bit per cycle.
// o_done/o_quot are valid combinationally in the final step; busy drops on the same edge.
module pwm_seq_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_high,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_busy,
    output logic             o_done,
    output logic [OUT_W-1:0] o_quot,
    output logic [CNT_W-1:0] o_period
);

    localparam int                STEP_W    = $clog2(OUT_W + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(OUT_W);
    localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

    logic              r_busy;
    logic [STEP_W-1:0] r_step;
    logic [CNT_W-1:0]  r_rem;
    logic [CNT_W-1:0]  r_den;
    logic [OUT_W:0]    r_bits;
    logic [OUT_W-1:0]  r_quo;

    logic [CNT_W:0]    w_trial;
    logic              w_fits;
    logic [CNT_W-1:0]  w_rem_nxt;
    logic [OUT_W:0]    w_quo_nxt;
    logic              w_last;

    // One restoring step; the quotient only needs OUT_W+1 bits because high never exceeds period.
    always_comb begin
        w_trial = {r_rem, r_bits[OUT_W]};
        w_fits  = (w_trial >= {1'b0, r_den});
        if (w_fits) begin
            w_rem_nxt = w_trial[CNT_W-1:0] - r_den;
        end else begin
            w_rem_nxt = w_trial[CNT_W-1:0];
        end
        w_quo_nxt = {r_quo, w_fits};
        w_last    = r_busy && (r_step == LAST_STEP);
        if (w_quo_nxt[OUT_W]) begin
            o_quot = {OUT_W{1'b1}};
        end else begin
            o_quot = w_quo_nxt[OUT_W-1:0];
        end
    end

    assign o_done   = w_last;
    assign o_busy   = r_busy;
    assign o_period = r_den;

    // Divider datapath: the upper numerator bits (high >> 1) preload the remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_step <= {STEP_W{1'b0}};
            r_rem  <= {CNT_W{1'b0}};
            r_den  <= {CNT_W{1'b0}};
            r_bits <= {(OUT_W+1){1'b0}};
            r_quo  <= {OUT_W{1'b0}};
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_step <= {STEP_W{1'b0}};
            r_rem  <= {1'b0, i_high[CNT_W-1:1]};
            r_den  <= i_period;
            r_bits <= {i_high[0], {OUT_W{1'b0}}};
            r_quo  <= {OUT_W{1'b0}};
        end else if (r_busy) begin
            r_busy <= !w_last;
            r_step <= r_step + STEP_ONE;
            r_rem  <= w_rem_nxt;
            r_bits <= {r_bits[OUT_W-1:0], 1'b0};
            r_quo  <= w_quo_nxt[OUT_W-1:0];
        end else begin
            r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period and high time of a PWM stream (rise to rise) and reports the duty code,
// flagging a stuck input after TIMEOUT cycles without a rising edge.
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int OUT_W       = DEF_OUT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [OUT_W-1:0] duty_out,
    output logic             duty_valid,
    output logic [CNT_W-1:0] period_out,
    output logic             stuck,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    meas_state_t            r_state;
    meas_state_t            w_state_nxt;
    logic [CNT_W-1:0]       r_per_cnt;
    logic [CNT_W-1:0]       r_hi_cnt;

    logic                   w_sync;
    logic                   w_rise;
    logic                   w_start;
    logic                   w_overrun;
    logic                   w_timeout;
    logic                   w_div_busy;
    logic                   w_div_done;
    logic [OUT_W-1:0]       w_div_quot;
    logic [CNT_W-1:0]       w_div_period;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_sync_d;

    // Input synchronizer and delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= {SYNC_STAGES{1'b0}};
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_sync_d <= w_sync;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle strobes; a completing division also frees the divider for a new start.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_overrun   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_MEAS;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MEAS: begin
                if (w_rise) begin
                    w_state_nxt = S_MEAS;
                    if (!w_div_busy || w_div_done) begin
                        w_start = 1'b1;
                    end else begin
                        w_overrun = 1'b1;
                    end
                end else if (r_per_cnt == TMO_LIMIT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_MEAS;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Gap-free period/high counters; the rise cycle itself counts as the first high cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt <= {CNT_W{1'b0}};
            r_hi_cnt  <= {CNT_W{1'b0}};
        end else if (w_rise) begin
            r_per_cnt <= CNT_ONE;
            r_hi_cnt  <= CNT_ONE;
        end else if (r_state == S_MEAS && !w_timeout) begin
            r_per_cnt <= r_per_cnt + CNT_ONE;
            r_hi_cnt  <= r_hi_cnt + {{(CNT_W-1){1'b0}}, w_sync};
        end else begin
            r_per_cnt <= {CNT_W{1'b0}};
            r_hi_cnt  <= {CNT_W{1'b0}};
        end
    end

    pwm_seq_div #(
        .CNT_W (CNT_W),
        .OUT_W (OUT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_high   (r_hi_cnt),
        .i_period (r_per_cnt),
        .o_busy   (w_div_busy),
        .o_done   (w_div_done),
        .o_quot   (w_div_quot),
        .o_period (w_div_period)
    );

    // Output registers; a stuck report overrides a coincident division result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_out   <= {OUT_W{1'b0}};
            duty_valid <= 1'b0;
            period_out <= {CNT_W{1'b0}};
            stuck      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            duty_valid <= w_timeout | w_div_done;
            overrun    <= w_overrun;
            if (w_timeout) begin
                duty_out   <= w_sync ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
                period_out <= {CNT_W{1'b0}};
            end else if (w_div_done) begin
                duty_out   <= w_div_quot;
                period_out <= w_div_period;
            end else begin
                duty_out   <= duty_out;
                period_out <= period_out;
            end
            if (w_timeout) begin
                stuck <= 1'b1;
            end else if (w_rise) begin
                stuck <= 1'b0;
            end else begin
                stuck <= stuck;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: directed and random PWM waveforms checked against an
// event-level model of when each duty/stuck/overrun report must appear.
module tb_pwm_duty_meter;

    localparam int CNT_W = 16;
    localparam int OUT_W = 8;
    localparam int SYNC  = 2;
    localparam int TMO   = 200;
    localparam int LAT   = SYNC + OUT_W + 1;

    typedef struct {
        int cyc;
        int duty;
        int per;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pwm_in;
    logic [OUT_W-1:0] duty_out;
    logic             duty_valid;
    logic [CNT_W-1:0] period_out;
    logic             stuck;
    logic             overrun;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    int   exp_ovr[$];
    int   obs_ovr[$];
    int   exp_clr[$];
    int   obs_clr[$];
    logic stuck_prev = 1'b0;

    int   armed;
    int   stuck_m;
    int   last_rise;
    int   last_high;
    int   last_accept;

    pwm_duty_meter #(
        .CNT_W       (CNT_W),
        .OUT_W       (OUT_W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .duty_valid (duty_valid),
        .period_out (period_out),
        .stuck      (stuck),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (duty_valid === 1'b1) obs_q.push_back('{cyc, int'(duty_out), int'(period_out)});
        if (overrun === 1'b1) obs_ovr.push_back(cyc);
        if (stuck_prev === 1'b1 && stuck === 1'b0 && rst_n === 1'b1) obs_clr.push_back(cyc);
        stuck_prev = stuck;
    end

    function automatic int exp_duty(input int h, input int p);
        int q;
        q = (h * (1 << OUT_W)) / p;
        return (q > (1 << OUT_W) - 1) ? (1 << OUT_W) - 1 : q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset(input int rc);
        for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].cyc > rc) exp_q.delete(i);
        for (int i = exp_ovr.size() - 1; i >= 0; i--) if (exp_ovr[i] > rc) exp_ovr.delete(i);
        for (int i = exp_clr.size() - 1; i >= 0; i--) if (exp_clr[i] > rc) exp_clr.delete(i);
        armed       = 0;
        stuck_m     = 0;
        last_accept = -100000;
    endtask

    // r: first clock edge that samples the new high level; h/p: this period's shape.
    task automatic model_rise(input int r, input int h, input int p);
        if (stuck_m != 0) begin
            exp_clr.push_back(r + SYNC);
            stuck_m = 0;
        end
        if (armed != 0) begin
            if (r - last_accept >= OUT_W + 3) begin
                exp_q.push_back('{r + LAT, exp_duty(last_high, r - last_rise), r - last_rise});
                last_accept = r;
            end else begin
                exp_ovr.push_back(r + SYNC);
            end
        end
        armed     = 1;
        last_rise = r;
        last_high = h;
        if (p > TMO) begin
            exp_q.push_back('{r + SYNC + TMO, (TMO < h) ? (1 << OUT_W) - 1 : 0, 0});
            armed   = 0;
            stuck_m = 1;
        end
    endtask

    task automatic drive_period(input int p, input int h);
        for (int i = 0; i < p; i++) begin
            @(negedge clk);
            if (i == 0) model_rise(cyc + 1, h, p);
            pwm_in = (i < h) ? 1'b1 : 1'b0;
        end
    endtask

    task automatic check_events();
        ev_t e;
        ev_t o;
        int  v;
        #1;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("valid_seen", 32'(obs_q.size() > 0), 32'd1);
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                chk("valid_cycle", o.cyc, e.cyc);
                chk("duty", o.duty, e.duty);
                chk("period", o.per, e.per);
            end
        end
        chk("extra_valid", obs_q.size(), 0);
        obs_q.delete();
        while (exp_ovr.size() > 0 && exp_ovr[0] <= cyc) begin
            v = exp_ovr.pop_front();
            chk("overrun_seen", 32'(obs_ovr.size() > 0), 32'd1);
            if (obs_ovr.size() > 0) chk("overrun_cycle", obs_ovr.pop_front(), v);
        end
        chk("extra_overrun", obs_ovr.size(), 0);
        obs_ovr.delete();
        while (exp_clr.size() > 0 && exp_clr[0] <= cyc) begin
            v = exp_clr.pop_front();
            chk("stuck_clear_seen", 32'(obs_clr.size() > 0), 32'd1);
            if (obs_clr.size() > 0) chk("stuck_clear_cycle", obs_clr.pop_front(), v);
        end
        chk("extra_stuck_clear", obs_clr.size(), 0);
        obs_clr.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_duty"}, duty_out, 0);
        chk({tag, "_period"}, period_out, 0);
        chk({tag, "_valid"}, duty_valid, 0);
        chk({tag, "_stuck"}, stuck, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int p;
        int h;
        int r;
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        model_reset(0);

        // Reset held while the input toggles.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pwm_in = k[0];
            #1 check_zero("in_reset");
        end
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        drive_period(20, 5);
        check_events();
        check_zero("one_edge");

        // Period 64, 16 high.
        repeat (4) drive_period(64, 16);
        check_events();
        chk("p64_duty", duty_out, 64);
        chk("p64_period", period_out, 64);

        // Period 100, 33 high: truncated quotient.
        repeat (3) drive_period(100, 33);
        check_events();
        chk("p100_duty", duty_out, 84);
        chk("p100_period", period_out, 100);

        // Stuck low, then stuck high.
        drive_period(250, 16);
        check_events();
        chk("stuck_low_flag", stuck, 1);
        chk("stuck_low_duty", duty_out, 0);
        chk("stuck_low_period", period_out, 0);
        drive_period(260, 255);
        check_events();
        chk("stuck_high_flag", stuck, 1);
        chk("stuck_high_duty", duty_out, 255);

        // Short period: overrun on alternate edges; duty held from stuck until next divide.
        drive_period(6, 3);
        #1;
        chk("clear_keeps_duty", duty_out, 255);
        chk("clear_stuck", stuck, 0);
        repeat (6) drive_period(6, 3);
        repeat (2) drive_period(40, 10);
        check_events();
        chk("p40_duty", duty_out, 64);

        // Random waveforms within the no-overrun, no-timeout range.
        repeat (10) begin
            p = $urandom_range(150, OUT_W + 3);
            h = $urandom_range(p - 1, 1);
            drive_period(p, h);
        end
        check_events();

        // Reset four cycles into a division.
        drive_period(50, 20);
        @(negedge clk);
        r = cyc + 1;
        model_rise(r, 20, 50);
        pwm_in = 1'b1;
        while (cyc < r + SYNC + 4) @(negedge clk);
        #2;
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        model_reset(cyc);
        repeat (3) @(negedge clk);
        #1 check_zero("mid_div_reset");
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_events();
        check_zero("after_reset");
        repeat (3) drive_period(30, 10);
        check_events();
        chk("recover_duty", duty_out, 85);
        chk("recover_period", period_out, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
